// File: rtl/tdm_demux_1_to_4_pkg.sv
// Shared definitions for the 4-slot TDM link: slot indices and receiver FSM encodings.
package tdm_demux_1_to_4_pkg;

  localparam int TDM_SLOTS = 4;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// 2-bit slot position counter: clear to 0, load to 1, advance with wrap-detect on slot 3.
module tdm_slot_counter
  import tdm_demux_1_to_4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load1,
  input  logic       advance,
  output logic [1:0] slot,
  output logic       wrap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= SLOT0;
    end else if (clear) begin
      slot <= SLOT0;
    end else if (load1) begin
      slot <= SLOT1;
    end else if (advance) begin
      slot <= slot + 2'd1;
    end
  end

  assign wrap = advance && (slot == SLOT3);

endmodule

// File: rtl/tdm_demux_1_to_4.sv
// TDM receiver: locks to the frame marker, collects four slots and publishes them together.
module tdm_demux_1_to_4
  import tdm_demux_1_to_4_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int LOCK_WAIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  localparam int CW = (LOCK_WAIT < 1) ? 1 : $clog2(LOCK_WAIT + 1);
  localparam logic [CW-1:0] LW = CW'(LOCK_WAIT);

  tdm_state_e       state_q, state_d;
  logic [1:0]       slot_q;
  logic             ctr_clear, ctr_load1, ctr_adv, wrap;
  logic             sh_wr;
  logic [1:0]       sh_idx;
  logic             err_d, cnt_clear, gate_open, commit;
  logic [CW-1:0]    good_q;
  logic [WIDTH-1:0] shadow_q [TDM_SLOTS-1];

  tdm_slot_counter u_slot_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ctr_clear),
    .load1   (ctr_load1),
    .advance (ctr_adv),
    .slot    (slot_q),
    .wrap    (wrap)
  );

  // Handshake: a slot is consumed on every cycle in_valid is high; there is no backpressure.
  always_comb begin
    state_d   = state_q;
    ctr_clear = 1'b0;
    ctr_load1 = 1'b0;
    ctr_adv   = 1'b0;
    sh_wr     = 1'b0;
    sh_idx    = SLOT0;
    err_d     = 1'b0;
    cnt_clear = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (in_valid && in_sync) begin
          sh_wr     = 1'b1;
          ctr_load1 = 1'b1;
          state_d   = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (in_valid) begin
          if (in_sync && (slot_q != SLOT0)) begin
            // Early marker: drop the partial frame and restart on this slot.
            err_d     = 1'b1;
            cnt_clear = 1'b1;
            sh_wr     = 1'b1;
            ctr_load1 = 1'b1;
          end else if (!in_sync && (slot_q == SLOT0)) begin
            err_d     = 1'b1;
            cnt_clear = 1'b1;
            ctr_clear = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            sh_wr   = (slot_q != SLOT3);
            sh_idx  = slot_q;
            ctr_adv = 1'b1;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // The counter saturates at LW, so equality is the "enough good frames" test.
  assign gate_open = (good_q == LW);
  assign commit    = wrap && gate_open;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HUNT;
      good_q    <= '0;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      for (int i = 0; i < TDM_SLOTS - 1; i++) shadow_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= commit;
      sync_err  <= err_d;
      if (sh_wr) begin
        case (sh_idx)
          SLOT0:   shadow_q[0] <= in_data;
          SLOT1:   shadow_q[1] <= in_data;
          SLOT2:   shadow_q[2] <= in_data;
          default: ;
        endcase
      end
      if (commit) begin
        out0 <= shadow_q[0];
        out1 <= shadow_q[1];
        out2 <= shadow_q[2];
        out3 <= in_data;
      end
      if (cnt_clear) begin
        good_q <= '0;
      end else if (wrap && !gate_open) begin
        good_q <= good_q + CW'(1);
      end
    end
  end

  assign slot   = slot_q;
  assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Bench for tdm_demux_1_to_4: two instances (LOCK_WAIT 0 and 2) against a frame-level queue model.
module tb_tdm_demux_1_to_4;

  localparam int W = 4;

  typedef struct packed {
    logic        locked;
    logic [1:0]  slot;
    logic        err;
    logic [1:0]  ov;
    logic [15:0] outa;
    logic [15:0] outb;
  } st_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_sync = 1'b0;

  logic [W-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic         ova, ovb, erra, errb, lka, lkb;
  logic [1:0]   sla, slb;

  tdm_demux_1_to_4 #(.WIDTH(W), .LOCK_WAIT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sync(in_sync),
    .out0(a0), .out1(a1), .out2(a2), .out3(a3), .out_valid(ova),
    .slot(sla), .locked(lka), .sync_err(erra)
  );

  tdm_demux_1_to_4 #(.WIDTH(W), .LOCK_WAIT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sync(in_sync),
    .out0(b0), .out1(b1), .out2(b2), .out3(b3), .out_valid(ovb),
    .slot(slb), .locked(lkb), .sync_err(errb)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  st_t         st_q[$];
  logic [15:0] exp_qa[$];
  logic [15:0] exp_qb[$];

  // ---------------- reference model (frame level) ----------------
  bit          m_locked;
  logic [W-1:0] m_frame[$];
  int          m_good[2];
  int          lock_wait[2] = '{0, 2};
  logic [15:0] m_out[2];

  task automatic model_reset();
    m_locked = 1'b0;
    m_frame.delete();
    m_good   = '{0, 0};
    m_out    = '{16'h0, 16'h0};
  endtask

  task automatic model_step(input logic v, input logic s, input logic [W-1:0] d, output st_t e);
    logic [15:0] word;
    e = '0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_frame.delete();
          m_frame.push_back(d);
          m_locked = 1'b1;
        end
      end else if (s) begin
        if (m_frame.size() != 0) begin
          e.err  = 1'b1;
          m_good = '{0, 0};
        end
        m_frame.delete();
        m_frame.push_back(d);
      end else if (m_frame.size() == 0) begin
        e.err    = 1'b1;
        m_locked = 1'b0;
        m_good   = '{0, 0};
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == 4) begin
          word = {m_frame[0], m_frame[1], m_frame[2], m_frame[3]};
          for (int i = 0; i < 2; i++) begin
            if (m_good[i] >= lock_wait[i]) begin
              m_out[i] = word;
              e.ov[i]  = 1'b1;
              if (i == 0) exp_qa.push_back(word);
              else        exp_qb.push_back(word);
            end else begin
              m_good[i]++;
            end
          end
          m_frame.delete();
        end
      end
    end
    e.locked = m_locked;
    e.slot   = 2'(m_frame.size());
    e.outa   = m_out[0];
    e.outb   = m_out[1];
  endtask

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    st_t e;
    @(negedge clk);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    model_step(v, s, d, e);
    st_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), W'($urandom));
  endtask

  task automatic send_frame(input logic [15:0] f, input int gap);
    drive(1'b1, 1'b1, f[15:12]); idle(gap);
    drive(1'b1, 1'b0, f[11:8]);  idle(gap);
    drive(1'b1, 1'b0, f[7:4]);   idle(gap);
    drive(1'b1, 1'b0, f[3:0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    model_reset();
    #1;
    chk("rst_outs_a", {16'h0, a0, a1, a2, a3}, 32'h0);
    chk("rst_outs_b", {16'h0, b0, b1, b2, b3}, 32'h0);
    chk("rst_flags_a", {27'h0, ova, erra, lka, sla}, 32'h0);
    chk("rst_flags_b", {27'h0, ovb, errb, lkb, slb}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  st_t me;
  always @(posedge clk) begin
    #1;
    if (st_q.size() > 0) begin
      me = st_q.pop_front();
      chk("status_a", {27'h0, lka, sla, erra, ova}, {27'h0, me.locked, me.slot, me.err, me.ov[0]});
      chk("status_b", {27'h0, lkb, slb, errb, ovb}, {27'h0, me.locked, me.slot, me.err, me.ov[1]});
      chk("held_a", {16'h0, a0, a1, a2, a3}, {16'h0, me.outa});
      chk("held_b", {16'h0, b0, b1, b2, b3}, {16'h0, me.outb});
      if (ova) begin
        if (exp_qa.size() == 0) chk("frame_a_unexpected", 32'h1, 32'h0);
        else chk("frame_a", {16'h0, a0, a1, a2, a3}, {16'h0, exp_qa.pop_front()});
      end
      if (ovb) begin
        if (exp_qb.size() == 0) chk("frame_b_unexpected", 32'h1, 32'h0);
        else chk("frame_b", {16'h0, b0, b1, b2, b3}, {16'h0, exp_qb.pop_front()});
      end
    end else if (rst_n) begin
      chk("idle_out_valid", {30'h0, ova, ovb}, 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  int p;
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // back-to-back frame, then gapped frame
    send_frame(16'hABCD, 0);
    idle(2);
    send_frame(16'h1234, 3);
    idle(2);

    // partial frame interrupted by an early marker, then a clean frame
    send_frame(16'h5678, 0);
    drive(1'b1, 1'b1, 4'h9);
    drive(1'b1, 1'b0, 4'hE);
    send_frame(16'hCAFE, 0);
    idle(2);

    // loss of lock: slot 0 without marker, then unmarked slots are ignored
    drive(1'b1, 1'b0, 4'h7);
    drive(1'b1, 1'b0, 4'h6);
    drive(1'b1, 1'b0, 4'h5);
    send_frame(16'h2468, 1);

    // fresh lock-wait sequence: three good frames back-to-back
    do_reset();
    send_frame(16'h1111, 0);
    send_frame(16'h2222, 0);
    send_frame(16'h3333, 0);
    idle(2);

    // reset mid-frame at slot 2, then a full frame
    drive(1'b1, 1'b1, 4'hF);
    drive(1'b1, 1'b0, 4'hE);
    do_reset();
    send_frame(16'h9ABC, 0);
    idle(2);

    // randomized traffic with occasional framing faults and resets
    p = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        p = 0;
      end else if ($urandom_range(0, 3) != 0) begin
        drive(1'b1, (p == 0) ^ ($urandom_range(0, 19) == 0), W'($urandom));
        p = (p + 1) % 4;
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), W'($urandom));
      end
    end
    idle(3);
    @(negedge clk);

    chk("pending_a", 32'(exp_qa.size()), 32'h0);
    chk("pending_b", 32'(exp_qb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
